// File: rtl/ram_arbiter.sv
// Two-requester (CPU, program loader) arbiter in front of a single-port synchronous RAM.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; the default gives the CPU priority.
module ram_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wren,
  input  logic [31:0]       ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, CAPTURE} state_t;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_LD  = 1'b1;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              ram_wren_q, ram_wren_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              ld_gnt_q, ld_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ld_rvalid_q, ld_rvalid_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       ld_rdata_q, ld_rdata_d;
  logic              win_ld;
  logic              win_we;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  logic last_winner_q, last_winner_d;

  // On a tie, the requester that did not win last time goes first.
  assign win_ld = (cpu_req && ld_req) ? (last_winner_q == SEL_CPU) : ld_req;

  always_comb begin
    last_winner_d = last_winner_q;
    if (state_q == IDLE && (cpu_req || ld_req)) begin
      last_winner_d = win_ld;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= SEL_LD;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end
`else
  assign win_ld = ld_req && !cpu_req;
`endif

  assign win_we = win_ld ? ld_we : cpu_we;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    we_d         = we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_wren_d   = 1'b0;
    cpu_gnt_d    = 1'b0;
    ld_gnt_d     = 1'b0;
    cpu_rvalid_d = 1'b0;
    ld_rvalid_d  = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ld_rdata_d   = ld_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cpu_req || ld_req) begin
          sel_d       = win_ld;
          we_d        = win_we;
          ram_addr_d  = win_ld ? ld_addr : cpu_addr;
          ram_wdata_d = win_ld ? ld_wdata : cpu_wdata;
          ram_wren_d  = win_we;
          cpu_gnt_d   = !win_ld;
          ld_gnt_d    = win_ld;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        // RAM data for the address presented in ISSUE is valid now.
        if (sel_q == SEL_LD) begin
          ld_rdata_d = ram_rdata;
        end else begin
          cpu_rdata_d = ram_rdata;
        end
        cpu_rvalid_d = (sel_q == SEL_CPU);
        ld_rvalid_d  = (sel_q == SEL_LD);
        state_d      = CAPTURE;
      end
      CAPTURE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= SEL_CPU;
      we_q         <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_wren_q   <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      ld_gnt_q     <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ld_rvalid_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_wren_q   <= ram_wren_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ld_gnt_q     <= ld_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ld_rvalid_q  <= ld_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign ld_gnt     = ld_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ld_rvalid  = ld_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ld_rdata   = ld_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_wren   = ram_wren_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM attached.
// Honours RAM_ARBITER_ROUND_ROBIN_EN when choosing expected grant order.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic        ld_gnt, ld_rvalid;
  logic [31:0] ld_rdata;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_wren;
  logic [31:0] ram_rdata;
  logic        busy;

  logic [31:0] mem [0:65535];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wren_cnt = 0, busy_cnt = 0, cpu_rv_cnt = 0, ld_rv_cnt = 0, both_gnt_cnt = 0;
  logic [15:0] last_wren_addr = '0;
  bit gnt_order[$];
  int ld_gnt_cyc[$];

  ram_arbiter #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ram_wren) begin
      wren_cnt <= wren_cnt + 1;
      last_wren_addr <= ram_addr;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
    if (cpu_rvalid) cpu_rv_cnt <= cpu_rv_cnt + 1;
    if (ld_rvalid) ld_rv_cnt <= ld_rv_cnt + 1;
    if (cpu_gnt && ld_gnt) both_gnt_cnt <= both_gnt_cnt + 1;
    if (cpu_gnt) gnt_order.push_back(1'b0);
    if (ld_gnt) begin
      gnt_order.push_back(1'b1);
      ld_gnt_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit is_ld, input bit req, input bit we,
                       input logic [15:0] a, input logic [31:0] d);
    if (is_ld) begin
      ld_req = req; ld_we = we; ld_addr = a; ld_wdata = d;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " cpu_gnt"}, 32'(cpu_gnt), 32'd0);
    check({tag, " ld_gnt"}, 32'(ld_gnt), 32'd0);
    check({tag, " cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    check({tag, " ld_rvalid"}, 32'(ld_rvalid), 32'd0);
    check({tag, " ram_wren"}, 32'(ram_wren), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " cpu_rdata"}, cpu_rdata, 32'd0);
    check({tag, " ld_rdata"}, ld_rdata, 32'd0);
    check({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, " ram_wdata"}, ram_wdata, 32'd0);
  endtask

  // One access from an idle requester; called just after a rising edge.
  task automatic access(input string tag, input bit is_ld, input bit we,
                        input logic [15:0] a, input logic [31:0] d,
                        output int gnt_lat, output int rv_lat, output logic [31:0] rdata);
    int start;
    bit seen;
    start = cyc;
    gnt_lat = -1; rv_lat = -1; rdata = '0;
    drive(is_ld, 1'b1, we, a, d);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (is_ld ? ld_gnt : cpu_gnt) begin
        seen = 1'b1;
        gnt_lat = cyc - start;
        drive(is_ld, 1'b0, we, a, d);
      end
    end
    check({tag, " gnt seen"}, 32'(seen), 32'd1);
    drive(is_ld, 1'b0, we, a, d);
    if (seen && !we) begin
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (is_ld ? ld_rvalid : cpu_rvalid) begin
          seen = 1'b1;
          rv_lat = cyc - start;
          rdata = is_ld ? ld_rdata : cpu_rdata;
        end
      end
      check({tag, " rvalid seen"}, 32'(seen), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  // Back-to-back writes with req held high across grants.
  task automatic stream(input string tag, input bit is_ld, input int n,
                        input logic [15:0] base, input logic [31:0] dbase);
    int k;
    int guard;
    k = 0; guard = 0;
    drive(is_ld, 1'b1, 1'b1, base, dbase);
    while (k < n && guard < 40 * n) begin
      @(negedge clk);
      guard++;
      if (is_ld ? ld_gnt : cpu_gnt) begin
        k++;
        if (k < n) drive(is_ld, 1'b1, 1'b1, 16'(base + k), dbase + k);
        else       drive(is_ld, 1'b0, 1'b1, 16'(base + k), dbase + k);
      end
    end
    check({tag, " grants"}, 32'(k), 32'(n));
    drive(is_ld, 1'b0, 1'b0, base, dbase);
    @(posedge clk); #1;
  endtask

  function automatic bit exp_order(input int i);
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    return (i % 2) == 1;
`else
    return i >= 4;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gl, rl, s0, s1, s2, s3, o0, l0;
    logic [31:0] rd;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b0;

    // CPU write
    s0 = wren_cnt; s1 = busy_cnt;
    access("w33", 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, gl, rl, rd);
    check("w33 gnt lat", 32'(gl), 32'd1);
    check("w33 wren cycles", 32'(wren_cnt - s0), 32'd1);
    check("w33 wren addr", 32'(last_wren_addr), 32'h0010);
    check("w33 busy cycles", 32'(busy_cnt - s1), 32'd1);
    check("w33 mem", mem[16'h0010], 32'hDEADBEEF);

    // CPU read-back
    s0 = wren_cnt; s1 = busy_cnt; s2 = ld_rv_cnt;
    access("r34", 1'b0, 1'b0, 16'h0010, 32'h0, gl, rl, rd);
    check("r34 gnt lat", 32'(gl), 32'd1);
    check("r34 rvalid lat", 32'(rl), 32'd3);
    check("r34 rdata", rd, 32'hDEADBEEF);
    check("r34 ld_rvalid", 32'(ld_rv_cnt - s2), 32'd0);
    check("r34 busy cycles", 32'(busy_cnt - s1), 32'd3);
    check("r34 no wren", 32'(wren_cnt - s0), 32'd0);
    check("r34 ld_rdata kept", ld_rdata, 32'd0);

    // Loader write and read; CPU side must stay untouched
    s3 = cpu_rv_cnt;
    access("ldw", 1'b1, 1'b1, 16'h0020, 32'h12345678, gl, rl, rd);
    check("ldw gnt lat", 32'(gl), 32'd1);
    access("ldr", 1'b1, 1'b0, 16'h0020, 32'h0, gl, rl, rd);
    check("ldr rvalid lat", 32'(rl), 32'd3);
    check("ldr rdata", rd, 32'h12345678);
    check("ldr cpu_rdata kept", cpu_rdata, 32'hDEADBEEF);
    check("ldr cpu_rvalid", 32'(cpu_rv_cnt - s3), 32'd0);

    // Simultaneous write streams
    o0 = gnt_order.size(); s0 = both_gnt_cnt;
    fork
      stream("c35", 1'b0, 4, 16'h0100, 32'hC0000000);
      stream("l35", 1'b1, 4, 16'h0200, 32'hD0000000);
    join
    check("r35 total grants", 32'(gnt_order.size() - o0), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (o0 + i < gnt_order.size())
        check($sformatf("r35 order %0d", i), 32'(gnt_order[o0 + i]), 32'(exp_order(i)));
    end
    check("r35 dual grant", 32'(both_gnt_cnt - s0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("r35 cpu mem %0d", i), mem[16'h0100 + i], 32'hC0000000 + i);
      check($sformatf("r35 ld mem %0d", i), mem[16'h0200 + i], 32'hD0000000 + i);
    end

    // Loader streams 256 writes
    l0 = ld_gnt_cyc.size();
    stream("s36", 1'b1, 256, 16'h0000, 32'h5A5A0000);
    check("s36 ld_gnt pulses", 32'(ld_gnt_cyc.size() - l0), 32'd256);
    for (int i = 1; i < 256; i++) begin
      if (l0 + i < ld_gnt_cyc.size())
        check($sformatf("s36 spacing %0d", i), 32'(ld_gnt_cyc[l0 + i] - ld_gnt_cyc[l0 + i - 1]), 32'd2);
    end
    for (int i = 0; i < 256; i++) begin
      check($sformatf("s36 mem %0d", i), mem[i], 32'h5A5A0000 + i);
    end

    // Reset during RDWAIT of a loader read
    drive(1'b1, 1'b1, 1'b0, 16'h0005, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ld_gnt) begin
        seen = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0005, 32'h0);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0005, 32'h0);
    check("r37 gnt seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    check("r37 busy in rdwait", 32'(busy), 32'd1);
    s2 = ld_rv_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_vals("r37");
    repeat (4) @(posedge clk);
    #1;
    check("r37 no ld_rvalid", 32'(ld_rv_cnt - s2), 32'd0);
    access("r37 cpu", 1'b0, 1'b0, 16'h0010, 32'h0, gl, rl, rd);
    check("r37 cpu gnt lat", 32'(gl), 32'd1);
    check("r37 cpu rvalid lat", 32'(rl), 32'd3);
    check("r37 cpu rdata", rd, 32'h5A5A0010);
    access("r37 ld", 1'b1, 1'b0, 16'h0007, 32'h0, gl, rl, rd);
    check("r37 ld rvalid lat", 32'(rl), 32'd3);
    check("r37 ld rdata", rd, 32'h5A5A0007);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
